// File: rtl/cd_csr_arb_pkg.sv
// Shared types and defaults for the two-requester CDBUS CSR arbiter.
package cd_csr_arb_pkg;

    localparam int unsigned DefRdLat       = 1;
    localparam int unsigned DefLockTimeout = 255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    // Requester index: 0 -> a0, 1 -> a1
    typedef logic req_idx_t;

    typedef logic [4:0] csr_addr_t;
    typedef logic [7:0] csr_data_t;

endpackage

// File: rtl/cd_csr_arb_if.sv
// Requester command/return signals and the shared CSR port of cd_csr_arb.
interface cd_csr_arb_if;
    import cd_csr_arb_pkg::*;

    csr_addr_t a0_address;
    logic      a0_read;
    logic      a0_write;
    csr_data_t a0_writedata;
    logic      a0_lock;
    logic      a0_waitrequest;
    csr_data_t a0_readdata;
    logic      a0_rdvalid;

    csr_addr_t a1_address;
    logic      a1_read;
    logic      a1_write;
    csr_data_t a1_writedata;
    logic      a1_lock;
    logic      a1_waitrequest;
    csr_data_t a1_readdata;
    logic      a1_rdvalid;

    csr_addr_t csr_address;
    logic      csr_read;
    logic      csr_write;
    csr_data_t csr_writedata;
    csr_data_t csr_readdata;

    // Requester/CSR-device side
    modport master (
        output a0_address, a0_read, a0_write, a0_writedata, a0_lock,
        input  a0_waitrequest, a0_readdata, a0_rdvalid,
        output a1_address, a1_read, a1_write, a1_writedata, a1_lock,
        input  a1_waitrequest, a1_readdata, a1_rdvalid,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata
    );

    // Arbiter side
    modport slave (
        input  a0_address, a0_read, a0_write, a0_writedata, a0_lock,
        output a0_waitrequest, a0_readdata, a0_rdvalid,
        input  a1_address, a1_read, a1_write, a1_writedata, a1_lock,
        output a1_waitrequest, a1_readdata, a1_rdvalid,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata
    );

endinterface

// File: rtl/cd_rr_arb2.sv
// Two-way round-robin pick; the pointer names the requester favoured on a tie.
module cd_rr_arb2
    import cd_csr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] ack,
    input  logic       force_en,
    input  req_idx_t   force_prio,
    output logic [1:0] gnt
);

    req_idx_t prio_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt           = 2'b00;
            gnt[prio_q]   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (force_en) begin
            prio_q <= force_prio;
        end else if (ack[0]) begin
            prio_q <= 1'b1;
        end else if (ack[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cd_csr_arb.sv
// Arbitrates two lockable requesters onto one CSR port and routes read data
// back to whichever requester issued each read.
module cd_csr_arb
    import cd_csr_arb_pkg::*;
#(
    parameter int unsigned RD_LAT       = DefRdLat,
    parameter int unsigned LOCK_TIMEOUT = DefLockTimeout
) (
    input  logic         clk,
    input  logic         reset,
    cd_csr_arb_if.slave  bus,
    output logic [1:0]   grant,
    output logic         lock_timeout
);

    logic [1:0] rd, wr, req, lock_raw, lk, acc, rr_gnt;
    logic [1:0] blk_q, blk_d;
    state_e     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    req_idx_t   own_idx, acc_idx, force_prio;
    logic       force_en;

    assign rd       = {bus.a1_read, bus.a0_read};
    assign wr       = {bus.a1_write, bus.a0_write};
    assign req      = rd | wr;
    assign lock_raw = {bus.a1_lock, bus.a0_lock};
    // A requester whose lock was revoked is served unlocked until it drops lock
    assign lk       = lock_raw & ~blk_q;
    assign own_idx  = req_idx_t'(state_q == StOwn1);
    assign acc_idx  = acc[1];

    cd_rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (acc),
        .force_en  (force_en),
        .force_prio(force_prio),
        .gnt       (rr_gnt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q & lock_raw;
        acc          = 2'b00;
        grant        = 2'b00;
        lock_timeout = 1'b0;
        force_en     = 1'b0;
        force_prio   = 1'b0;
        unique case (state_q)
            StIdle: begin
                acc   = rr_gnt;
                grant = rr_gnt;
                cnt_d = '0;
                if (acc[0] && lk[0]) begin
                    state_d = StOwn0;
                end else if (acc[1] && lk[1]) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                acc[own_idx]   = req[own_idx];
                grant[own_idx] = 1'b1;
                if (!lk[own_idx]) begin
                    state_d = StIdle;
                end
                if (req[own_idx]) begin
                    cnt_d = '0;
                end else if (cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
                    // Revoke: no grant this cycle, the other side wins next
                    lock_timeout   = 1'b1;
                    grant          = 2'b00;
                    state_d        = StIdle;
                    cnt_d          = '0;
                    blk_d[own_idx] = 1'b1;
                    force_en       = 1'b1;
                    force_prio     = ~own_idx;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (reset) begin
            acc          = 2'b00;
            grant        = 2'b00;
            lock_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            blk_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    assign bus.a0_waitrequest = ~acc[0];
    assign bus.a1_waitrequest = ~acc[1];

    csr_addr_t            csr_address_q;
    csr_data_t            csr_writedata_q, readdata0_q, readdata1_q;
    logic                 csr_read_q, csr_write_q;
    req_idx_t             csr_who_q;
    logic [RD_LAT-1:0]    tag_vld_q;
    req_idx_t [RD_LAT-1:0] tag_who_q;
    logic [1:0]           rdvalid_q;
    csr_addr_t            sel_address;
    csr_data_t            sel_writedata;
    logic                 ret_vld;
    req_idx_t             ret_idx;

    assign sel_address   = acc_idx ? bus.a1_address : bus.a0_address;
    assign sel_writedata = acc_idx ? bus.a1_writedata : bus.a0_writedata;
    assign ret_vld       = tag_vld_q[RD_LAT-1];
    assign ret_idx       = tag_who_q[RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_address_q   <= '0;
            csr_writedata_q <= '0;
            csr_read_q      <= 1'b0;
            csr_write_q     <= 1'b0;
            csr_who_q       <= 1'b0;
            tag_vld_q       <= '0;
            tag_who_q       <= '0;
            rdvalid_q       <= 2'b00;
            readdata0_q     <= '0;
            readdata1_q     <= '0;
        end else begin
            csr_read_q  <= 1'b0;
            csr_write_q <= 1'b0;
            if (|acc) begin
                csr_read_q      <= rd[acc_idx];
                csr_write_q     <= wr[acc_idx] & ~rd[acc_idx];
                csr_address_q   <= sel_address;
                csr_writedata_q <= sel_writedata;
                csr_who_q       <= acc_idx;
            end
            // Stage k holds the issuer of the read strobed k+1 cycles ago
            tag_vld_q[0] <= csr_read_q;
            tag_who_q[0] <= csr_who_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_who_q[i] <= tag_who_q[i-1];
            end
            rdvalid_q <= 2'b00;
            if (ret_vld) begin
                rdvalid_q[ret_idx] <= 1'b1;
                if (ret_idx) begin
                    readdata1_q <= bus.csr_readdata;
                end else begin
                    readdata0_q <= bus.csr_readdata;
                end
            end
        end
    end

    assign bus.csr_address   = csr_address_q;
    assign bus.csr_writedata = csr_writedata_q;
    assign bus.csr_read      = csr_read_q;
    assign bus.csr_write     = csr_write_q;
    assign bus.a0_readdata   = readdata0_q;
    assign bus.a1_readdata   = readdata1_q;
    assign bus.a0_rdvalid    = rdvalid_q[0];
    assign bus.a1_rdvalid    = rdvalid_q[1];

endmodule

// File: doc/cd_csr_arb.md
CD_CSR_ARB -- requirements
Module: cd_csr_arb

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from csr_read strobe to valid csr_readdata (1..4).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 255: owner-idle cycles before a held lock is revoked (1..65535).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports aN_address  in  5, aN_read  in  1, aN_write  in  1, aN_writedata  in  8, aN_lock  in  1, per requester N=0,1: command inputs.
REQ-006 SHALL have ports aN_waitrequest  out  1, aN_readdata  out  8, aN_rdvalid  out  1, per requester N=0,1: handshake and read return.
REQ-007 SHALL have ports csr_address  out  5, csr_read  out  1, csr_write  out  1, csr_writedata  out  8, csr_readdata  in  8: shared CDBUS CSR port.
REQ-008 SHALL have ports grant  out  2 (one-hot owner, 00 when none) and lock_timeout  out  1 (one-cycle pulse).

Function
REQ-009 SHALL treat aN_read|aN_write as a request; command accepted in a cycle where it is high and aN_waitrequest is low; requester holds command stable while waitrequest is high.
REQ-010 SHALL drive aN_waitrequest combinationally from registered state and current requests; at most one requester accepted per cycle.
REQ-011 SHALL register the accepted command onto csr_* exactly one cycle after acceptance, strobe high for one cycle; csr_read and csr_write never both high.
REQ-012 SHALL return read data to the issuing requester RD_LAT+1 cycles after csr_read: aN_readdata registered, aN_rdvalid one-cycle pulse; total latency from acceptance RD_LAT+2.
REQ-013 SHALL accept back-to-back commands (one per cycle) and track read issuer with an RD_LAT-deep tag pipeline, so data reaches the issuer even if ownership changes meanwhile.
REQ-014 SHALL implement FSM IDLE, OWN0, OWN1.
REQ-015 IDLE: single request accepted same cycle; both requesting -> round-robin winner (requester not served last); RR pointer updated after every acceptance.
REQ-016 IDLE: accepted command with aN_lock=1 -> OWNN next cycle; with aN_lock=0 -> stay IDLE.
REQ-017 OWNN: only requester N accepted; other waits; stay while aN_lock=1; aN_lock=0 -> IDLE next cycle (a concurrent owner command with lock=0 is still accepted).
REQ-018 OWNN: 16-bit idle counter clears on each owner acceptance, increments otherwise; reaching LOCK_TIMEOUT -> IDLE, lock_timeout pulse, RR pointer favours the other requester.
REQ-019 After timeout, requester N's aN_lock SHALL be ignored (its commands serviced unlocked) until it deasserts aN_lock for at least one cycle.
REQ-020 grant SHALL show OWN0=01, OWN1=10; in IDLE, one-hot of requester accepted that cycle, else 00.
REQ-021 Owner releasing lock while other requester waits: other accepted in the first IDLE cycle.

Reset
REQ-022 While reset high: FSM IDLE, RR pointer favours requester 0, counter 0, tag pipeline empty, csr_read/csr_write/aN_rdvalid/lock_timeout 0, csr_address/csr_writedata/aN_readdata 0, grant 00, lock block flags clear.
REQ-023 Reset mid-operation SHALL drop in-flight reads; no aN_rdvalid for commands accepted before reset.
REQ-024 aN_waitrequest SHALL be high while reset is asserted.

Structure
REQ-025 Shared package cd_csr_arb_pkg SHALL hold FSM state encoding, requester index type, and default RD_LAT/LOCK_TIMEOUT constants.
REQ-026 Round-robin pick and pointer SHALL be one sub-module cd_rr_arb2 (req[1:0], ack -> grant one-hot).

Verification
REQ-027 a0 write addr 0x05 data 0xA5, a1 idle -> a0_waitrequest 0 same cycle; csr_write=1, csr_address=0x05, csr_writedata=0xA5 next cycle.
REQ-028 a0 and a1 read simultaneously after reset, csr_readdata 0x11 then 0x22 -> a0 first (a1 waits 1 cycle); a0_rdvalid with 0x11 at acceptance+3, a1_rdvalid with 0x22 one cycle later (RD_LAT=1).
REQ-029 a1 locks and writes 10 bytes to addr 0x0A while a0 requests throughout -> a0 waitrequest high until a1_lock drops, then a0 accepted in first IDLE cycle; no interleaving on csr_*.
REQ-030 a0 locks, then idles with lock held, LOCK_TIMEOUT=8 -> lock_timeout pulse 8 cycles after last acceptance, grant 00, waiting a1 accepted next.
REQ-031 a0 read accepted, a1 takes grant next cycle -> a0_rdvalid still at acceptance+RD_LAT+2 with correct data; a1_rdvalid stays 0.
REQ-032 reset asserted one cycle after a0 read acceptance -> csr_read 0, no a0_rdvalid, all outputs at reset values.
